ir_receiver_sm: RTL
===================

# ir_receiver_sm

Decodes the car-control IR packet (36 kHz carrier) back into a 4-bit direction command. Input is the demodulated envelope from the IR receiver module (high = carrier present). The block times each burst and gap in carrier periods, classifies them, and presents the decoded COMMAND to the bus interface with a one-cycle valid strobe. It is the receive-side counterpart of the IR transmitter state machine and uses the same burst constants.

## Interface
- CLK_FREQ, 100_000_000: system clock frequency in Hz
- CARRIER_FREQ, 36_000: carrier frequency; tick period = CLK_FREQ/CARRIER_FREQ clocks (2777 at defaults)
- TOL, 6: ± tolerance in ticks applied to every nominal burst and gap length

- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- IR_IN  in  1  demodulated IR envelope, asynchronous
- COMMAND  out  4  last valid command: [3] right, [2] left, [1] back, [0] forward
- PACKET_VALID  out  1  one-cycle strobe; COMMAND updated on the same cycle
- ERROR  out  1  one-cycle strobe on a malformed packet
- BUSY  out  1  high while a packet is being decoded (any state except IDLE)

## Operation
- IR_IN passes a 2-flop synchronizer, then an edge detector. The rise/fall pulses restart the tick prescaler and clear the 9-bit length counter, which saturates at 511.
- Nominal lengths in ticks: start 191, gap 25, car-select 47, assert 47, de-assert 22. A length is in window when it is within nominal ± TOL, inclusive.
- States: IDLE, START, GAP, CARSEL, DIR, WAIT_LOW. A 2-bit index `dir_idx` (0..3) tracks the current direction burst: 0 = right, 1 = left, 2 = back, 3 = forward.
- IDLE:
  - Rise → START.
- START (input high):
  - Fall with start in window → GAP.
  - Fall out of window → IDLE silently. Noise is not an error.
  - Length exceeds 191+TOL while high → ERROR, then WAIT_LOW.
- GAP (input low):
  - Rise with gap in window → next burst state: CARSEL after start, DIR after CARSEL or a non-final DIR.
  - Rise with gap short → ERROR, then START. The new burst is treated as a start candidate.
  - Length reaches 25+TOL+1 → ERROR, then IDLE (timeout).
- CARSEL:
  - Fall with car-select in window → GAP.
  - Otherwise → ERROR, then GAP-or-IDLE: GAP is skipped and the state goes to IDLE.
- DIR:
  - Fall with assert in window → shadow bit = 1.
  - Fall with de-assert in window → shadow bit = 0.
  - Fall with any other length → ERROR, then IDLE.
  - Shadow bit for `dir_idx` maps to COMMAND[3 − dir_idx].
  - If `dir_idx` = 3 → copy shadow to COMMAND, pulse PACKET_VALID, go to IDLE. No trailing gap is required.
  - Otherwise → increment `dir_idx`, go to GAP.
- Any high burst longer than 191+TOL in a non-START state → ERROR, then WAIT_LOW.
- WAIT_LOW:
  - Low → IDLE.
- COMMAND changes only on PACKET_VALID. A failed packet leaves COMMAND unchanged.

## Timing
- Reset values: COMMAND 0, PACKET_VALID 0, ERROR 0, BUSY 0, state IDLE, `dir_idx` 0, shadow 0.
- RESET mid-packet aborts immediately and does not pulse ERROR.
- Latency: PACKET_VALID is asserted 3 CLK cycles after the final falling edge of IR_IN (2 synchronizer stages + 1 registered decision).
- ERROR and PACKET_VALID are never asserted on the same cycle. Each pulse lasts exactly one cycle.
- Edge and timeout on the same cycle: the edge wins if the completed length is in window. Length is evaluated before the counter clears.
- BUSY rises on the cycle after the start rise is detected. It falls on the cycle PACKET_VALID or ERROR pulses, or on silent return to IDLE.

## Structure
- Shared package `ir_pkg`:
  - burst/gap nominal constants (also used by the transmitter)
  - direction bit indices
  - receiver state enum
  - `in_window(len, nom, tol)` function
- Sub-module `ir_edge_timer`:
  - synchronizer, edge detect, tick prescaler, saturating length counter
  - outputs `rise`, `fall`, `level`, `len[8:0]`
- Top contains the FSM, shadow register and output registers.

## Test plan
- Nominal packet, COMMAND bits 1010: bursts 191/25/47/25/47/25/22/25/47/25/22. Expected: PACKET_VALID once, COMMAND = 4'b1010, ERROR never.
- All de-asserted, with every length at nominal ± TOL extremes. Expected: COMMAND = 0000, PACKET_VALID once.
- 100-tick lone burst. Expected: no PACKET_VALID, no ERROR, BUSY back to 0 within 3 cycles of the fall.
- Car-select burst of 30 ticks. Expected: one ERROR pulse, COMMAND keeps its previous value (pre-load 4'b0101 first).
- Stream stops after the right burst. Expected: ERROR at gap tick 32, BUSY low. A following nominal packet with 0001 decodes correctly.
- RESET asserted during the left burst. Expected: all outputs 0 the next cycle, no ERROR. A subsequent packet with 1111 decodes to 4'b1111.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared IR car-control constants, receiver states and window helper.
// Used by both the transmitter and the receiver side.
package ir_pkg;

  localparam int START_LEN    = 191;
  localparam int GAP_LEN      = 25;
  localparam int CARSEL_LEN   = 47;
  localparam int ASSERT_LEN   = 47;
  localparam int DEASSERT_LEN = 22;
  localparam int LEN_MAX      = 511;

  localparam int DIR_RIGHT = 3;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_BACK  = 1;
  localparam int DIR_FWD   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_GAP,
    ST_CARSEL,
    ST_DIR,
    ST_WAIT_LOW
  } rx_state_t;

  function automatic logic in_window(
    input logic [8:0] len,
    input int         nom,
    input int         tol
  );
    int l;
    l = int'(len);
    return (l >= nom - tol) && (l <= nom + tol);
  endfunction

endpackage

// File: rtl/ir_edge_timer.sv
// Synchronizes the IR envelope, detects edges and measures each
// burst/gap in carrier ticks with a saturating counter.
module ir_edge_timer #(
  parameter int TICK = 2777
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       rise,
  output logic       fall,
  output logic       level,
  output logic [8:0] len
);

  localparam int PW = $clog2(TICK + 1);

  logic          s1;
  logic          s2;
  logic          prev;
  logic [PW-1:0] presc;

  assign rise  = s2 & ~prev;
  assign fall  = ~s2 & prev;
  assign level = s2;

  // Restarting at 1 makes len equal the whole ticks since the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      prev  <= 1'b0;
      presc <= '0;
      len   <= '0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
      if (rise | fall) begin
        presc <= PW'(1);
        len   <= '0;
      end else if (presc == PW'(TICK - 1)) begin
        presc <= '0;
        if (len != 9'd511)
          len <= len + 9'd1;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: rtl/ir_receiver_sm.sv
// IR car-control packet receiver: classifies bursts and gaps and
// presents the decoded 4-bit direction command with a valid strobe.
module ir_receiver_sm
  import ir_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int CARRIER_FREQ = 36_000,
  parameter int TOL          = 6
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IR_IN,
  output logic [3:0] COMMAND,
  output logic       PACKET_VALID,
  output logic       ERROR,
  output logic       BUSY
);

  localparam int TICK = CLK_FREQ / CARRIER_FREQ;

  localparam logic [8:0] LONG_MAX = 9'(START_LEN + TOL);
  localparam logic [8:0] GAP_TMO  = 9'(GAP_LEN + TOL + 1);

  logic       rise;
  logic       fall;
  logic       level;
  logic [8:0] len;

  rx_state_t  state;
  logic [1:0] dir_idx;
  logic [3:0] shadow;
  logic [3:0] shadow_nxt;
  logic       to_carsel;
  logic       dir_hi;
  logic       dir_lo;
  logic       too_long;

  ir_edge_timer #(
    .TICK(TICK)
  ) u_timer (
    .clk  (CLK),
    .rst  (RESET),
    .din  (IR_IN),
    .rise (rise),
    .fall (fall),
    .level(level),
    .len  (len)
  );

  assign dir_hi   = in_window(len, ASSERT_LEN, TOL);
  assign dir_lo   = in_window(len, DEASSERT_LEN, TOL);
  assign too_long = level && (len > LONG_MAX);
  assign BUSY     = (state != ST_IDLE);

  // dir_idx 0 (right) lands on bit 3, 3 (forward) on bit 0.
  always_comb begin
    shadow_nxt = shadow;
    shadow_nxt[~dir_idx] = dir_hi;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= ST_IDLE;
      dir_idx      <= '0;
      shadow       <= '0;
      to_carsel    <= 1'b0;
      COMMAND      <= '0;
      PACKET_VALID <= 1'b0;
      ERROR        <= 1'b0;
    end else begin
      PACKET_VALID <= 1'b0;
      ERROR        <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (rise)
            state <= ST_START;
        end
        ST_START: begin
          if (fall) begin
            if (in_window(len, START_LEN, TOL)) begin
              state     <= ST_GAP;
              to_carsel <= 1'b1;
              dir_idx   <= '0;
              shadow    <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else if (too_long) begin
            ERROR <= 1'b1;
            state <= ST_WAIT_LOW;
          end
        end
        ST_GAP: begin
          if (rise) begin
            if (in_window(len, GAP_LEN, TOL)) begin
              state <= to_carsel ? ST_CARSEL : ST_DIR;
            end else begin
              ERROR <= 1'b1;
              state <= ST_START;
            end
          end else if (len >= GAP_TMO) begin
            ERROR <= 1'b1;
            state <= ST_IDLE;
          end
        end
        ST_CARSEL: begin
          if (fall) begin
            if (in_window(len, CARSEL_LEN, TOL)) begin
              state     <= ST_GAP;
              to_carsel <= 1'b0;
            end else begin
              ERROR <= 1'b1;
              state <= ST_IDLE;
            end
          end else if (too_long) begin
            ERROR <= 1'b1;
            state <= ST_WAIT_LOW;
          end
        end
        ST_DIR: begin
          if (fall) begin
            if (dir_hi || dir_lo) begin
              shadow <= shadow_nxt;
              if (dir_idx == 2'd3) begin
                COMMAND      <= shadow_nxt;
                PACKET_VALID <= 1'b1;
                state        <= ST_IDLE;
              end else begin
                dir_idx <= dir_idx + 2'd1;
                state   <= ST_GAP;
              end
            end else begin
              ERROR <= 1'b1;
              state <= ST_IDLE;
            end
          end else if (too_long) begin
            ERROR <= 1'b1;
            state <= ST_WAIT_LOW;
          end
        end
        ST_WAIT_LOW: begin
          if (!level)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
